// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller_if
// Description : Bundle between the multicycle controller and its datapath.
//               master = controller side (takes IR/flags/handshake, drives
//               control selects); slave = datapath side.
//   instruction      IR contents (cond/op/funct/rd fields)
//   alu_flags        NZCV produced by the ALU this cycle
//   mem_ready        memory access completes in a cycle where it is 1
//   pc_write .. alu_control   datapath control outputs
//   illegal          one-cycle pulse on an undefined opcode
//   state            current FSM state (debug)
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_controller_if;
    logic [31:0] instruction;
    logic [3:0]  alu_flags;
    logic        mem_ready;
    logic        pc_write;
    logic        address_source;
    logic        memory_write;
    logic        ir_write;
    logic        register_write;
    logic        alu_source_a;
    logic [1:0]  alu_source_b;
    logic [1:0]  result_source;
    logic [1:0]  immediate_source;
    logic [1:0]  register_source;
    logic [1:0]  alu_control;
    logic        illegal;
    logic [3:0]  state;

    modport master (
        input  instruction, alu_flags, mem_ready,
        output pc_write, address_source, memory_write, ir_write,
               register_write, alu_source_a, alu_source_b, result_source,
               immediate_source, register_source, alu_control, illegal, state
    );

    modport slave (
        output instruction, alu_flags, mem_ready,
        input  pc_write, address_source, memory_write, ir_write,
               register_write, alu_source_a, alu_source_b, result_source,
               immediate_source, register_source, alu_control, illegal, state
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Multicycle ARM-style control unit. FSM sequences fetch,
//               decode, memory, execute, writeback and branch steps and
//               gates architectural writes with the condition check against
//               an internal NZCV register.
//   clock          sole clock, rising edge
//   reset          asynchronous, active-low
//   bus            multicycle_controller_if.master (IR, flags, handshake,
//                  datapath selects, illegal pulse, debug state)
//   retired_count  RETIRE_W-bit retired-instruction counter, present only
//                  when the macro RETIRE_COUNT_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
    parameter int RETIRE_W = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    multicycle_controller_if.master    bus
`ifdef RETIRE_COUNT_EN
    ,
    output logic [RETIRE_W-1:0]        retired_count
`endif
);

    localparam logic [3:0] C_FETCH    = 4'd0;
    localparam logic [3:0] C_DECODE   = 4'd1;
    localparam logic [3:0] C_MEMADR   = 4'd2;
    localparam logic [3:0] C_MEMREAD  = 4'd3;
    localparam logic [3:0] C_MEMWB    = 4'd4;
    localparam logic [3:0] C_MEMWRITE = 4'd5;
    localparam logic [3:0] C_EXECUTER = 4'd6;
    localparam logic [3:0] C_EXECUTEI = 4'd7;
    localparam logic [3:0] C_ALUWB    = 4'd8;
    localparam logic [3:0] C_BRANCH   = 4'd9;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [3:0] r_nzcv;
    logic       w_cond_pass;

    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic [5:0] w_funct;
    logic       w_rd_pc;
    logic       w_unused_bits;

    assign w_cond        = bus.instruction[31:28];
    assign w_op          = bus.instruction[27:26];
    assign w_funct       = bus.instruction[25:20];
    assign w_rd_pc       = (bus.instruction[15:12] == 4'hF);
    assign w_unused_bits = ^{bus.instruction[19:16], bus.instruction[11:0]};

    // Condition evaluation always uses the registered flags, never the
    // flags the ALU is producing in the current cycle.
    always_comb begin
        w_cond_pass = 1'b0;
        case (w_cond)
            4'b0000: w_cond_pass = r_nzcv[2];
            4'b0001: w_cond_pass = ~r_nzcv[2];
            4'b0010: w_cond_pass = r_nzcv[1];
            4'b0011: w_cond_pass = ~r_nzcv[1];
            4'b0100: w_cond_pass = r_nzcv[3];
            4'b0101: w_cond_pass = ~r_nzcv[3];
            4'b0110: w_cond_pass = r_nzcv[0];
            4'b0111: w_cond_pass = ~r_nzcv[0];
            4'b1000: w_cond_pass = r_nzcv[1] & ~r_nzcv[2];
            4'b1001: w_cond_pass = ~r_nzcv[1] | r_nzcv[2];
            4'b1010: w_cond_pass = (r_nzcv[3] == r_nzcv[0]);
            4'b1011: w_cond_pass = (r_nzcv[3] != r_nzcv[0]);
            4'b1100: w_cond_pass = ~r_nzcv[2] & (r_nzcv[3] == r_nzcv[0]);
            4'b1101: w_cond_pass = r_nzcv[2] | (r_nzcv[3] != r_nzcv[0]);
            4'b1110: w_cond_pass = 1'b1;
            default: w_cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        w_next = C_FETCH;
        case (r_state)
            C_FETCH:    w_next = bus.mem_ready ? C_DECODE : C_FETCH;
            C_DECODE: begin
                case (w_op)
                    2'b00:   w_next = w_funct[5] ? C_EXECUTEI : C_EXECUTER;
                    2'b01:   w_next = C_MEMADR;
                    2'b10:   w_next = C_BRANCH;
                    default: w_next = C_FETCH;
                endcase
            end
            C_MEMADR:   w_next = w_funct[0] ? C_MEMREAD : C_MEMWRITE;
            C_MEMREAD:  w_next = bus.mem_ready ? C_MEMWB : C_MEMREAD;
            C_MEMWRITE: w_next = bus.mem_ready ? C_FETCH : C_MEMWRITE;
            C_EXECUTER: w_next = C_ALUWB;
            C_EXECUTEI: w_next = C_ALUWB;
            default:    w_next = C_FETCH;
        endcase
    end

    always_comb begin
        bus.pc_write         = 1'b0;
        bus.address_source   = 1'b0;
        bus.memory_write     = 1'b0;
        bus.ir_write         = 1'b0;
        bus.register_write   = 1'b0;
        bus.alu_source_a     = 1'b0;
        bus.alu_source_b     = 2'b00;
        bus.result_source    = 2'b00;
        bus.alu_control      = 2'b00;
        bus.illegal          = 1'b0;
        bus.immediate_source = w_op;
        bus.register_source  = {w_op == 2'b01, w_op == 2'b10};
        case (r_state)
            C_FETCH: begin
                bus.alu_source_a  = 1'b1;
                bus.alu_source_b  = 2'b10;
                bus.result_source = 2'b10;
                // Held low while reset is asserted so no IR/PC load can
                // slip through during reset.
                bus.ir_write      = bus.mem_ready & reset;
                bus.pc_write      = bus.mem_ready & reset;
            end
            C_DECODE: begin
                bus.alu_source_a  = 1'b1;
                bus.alu_source_b  = 2'b10;
                bus.result_source = 2'b10;
                bus.illegal       = (w_op == 2'b11);
            end
            C_MEMADR: begin
                bus.alu_source_b  = 2'b01;
            end
            C_MEMREAD: begin
                bus.address_source = 1'b1;
            end
            C_MEMWRITE: begin
                bus.address_source = 1'b1;
                bus.memory_write   = w_cond_pass;
            end
            C_MEMWB: begin
                bus.result_source  = 2'b01;
                bus.register_write = w_cond_pass;
                bus.pc_write       = w_cond_pass & w_rd_pc;
            end
            C_EXECUTER, C_EXECUTEI: begin
                bus.alu_source_b = (r_state == C_EXECUTEI) ? 2'b01 : 2'b00;
                case (w_funct[4:1])
                    4'b0100: bus.alu_control = 2'b00;
                    4'b0010: bus.alu_control = 2'b01;
                    4'b0000: bus.alu_control = 2'b10;
                    4'b1100: bus.alu_control = 2'b11;
                    default: bus.alu_control = 2'b00;
                endcase
            end
            C_ALUWB: begin
                bus.result_source  = 2'b00;
                bus.register_write = w_cond_pass;
                bus.pc_write       = w_cond_pass & w_rd_pc;
            end
            C_BRANCH: begin
                bus.alu_source_b       = 2'b01;
                bus.register_source[0] = 1'b1;
                bus.result_source      = 2'b10;
                bus.pc_write           = w_cond_pass;
            end
            default: begin
            end
        endcase
    end

    assign bus.state = r_state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= C_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Flags are captured only by flag-setting data-processing ops that pass.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_nzcv <= 4'b0000;
        end else if ((r_state == C_EXECUTER || r_state == C_EXECUTEI) &&
                     w_funct[0] && w_cond_pass) begin
            r_nzcv <= bus.alu_flags;
        end
    end

`ifdef RETIRE_COUNT_EN
    logic [RETIRE_W-1:0] r_retired;
    logic                w_retire;

    // Every completed instruction counts, condition-failed ones included;
    // the illegal path leaves from DECODE and is therefore not counted.
    assign w_retire = (w_next == C_FETCH) &&
                      (r_state == C_MEMWB || r_state == C_MEMWRITE ||
                       r_state == C_ALUWB || r_state == C_BRANCH);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + {{(RETIRE_W-1){1'b0}}, 1'b1};
        end
    end

    assign retired_count = r_retired;
`else
    if (RETIRE_W < 1) begin : g_retire_w_unused
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Scoreboard bench for multicycle_controller. The stimulus
//               process drives one cycle at a time and queues the expected
//               outputs for that cycle; a monitor pops and compares on the
//               falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    logic clock = 1'b0;
    logic reset;

    multicycle_controller_if bus();

`ifdef RETIRE_COUNT_EN
    logic [31:0] retired_count;
`endif

    multicycle_controller #(.RETIRE_W(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .bus           (bus.master)
`ifdef RETIRE_COUNT_EN
        ,
        .retired_count (retired_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int         idx;
        logic [3:0] st;
        logic       pcw, mw, rw, irw, ill, adr, srca;
        logic [1:0] srcb, res, aluc;
        logic       src_chk;
        logic [1:0] imm, regs;
        int         ret;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_n   = 0;
    int   ret_exp  = 0;

    task automatic chk(input int idx, input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL cycle%0d %s actual=%0d expected=%0d", idx, name, act, exp);
        end
    endtask

    // Monitor / scoreboard consumer
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.idx, "state",          int'(bus.state),          int'(e.st));
                chk(e.idx, "pc_write",       int'(bus.pc_write),       int'(e.pcw));
                chk(e.idx, "memory_write",   int'(bus.memory_write),   int'(e.mw));
                chk(e.idx, "register_write", int'(bus.register_write), int'(e.rw));
                chk(e.idx, "ir_write",       int'(bus.ir_write),       int'(e.irw));
                chk(e.idx, "illegal",        int'(bus.illegal),        int'(e.ill));
                chk(e.idx, "address_source", int'(bus.address_source), int'(e.adr));
                chk(e.idx, "alu_source_a",   int'(bus.alu_source_a),   int'(e.srca));
                chk(e.idx, "alu_source_b",   int'(bus.alu_source_b),   int'(e.srcb));
                chk(e.idx, "result_source",  int'(bus.result_source),  int'(e.res));
                chk(e.idx, "alu_control",    int'(bus.alu_control),    int'(e.aluc));
                if (e.src_chk) begin
                    chk(e.idx, "immediate_source", int'(bus.immediate_source), int'(e.imm));
                    chk(e.idx, "register_source",  int'(bus.register_source),  int'(e.regs));
                end
`ifdef RETIRE_COUNT_EN
                chk(e.idx, "retired_count", int'(retired_count), e.ret);
`endif
            end
        end
    end

    // Drive one cycle's inputs and queue what the DUT must show in it.
    task automatic step(input logic rst_v, input logic mr, input logic [3:0] st,
                        input logic pcw, input logic mw, input logic rw,
                        input logic irw, input logic ill, input logic adr,
                        input logic srca, input logic [1:0] srcb,
                        input logic [1:0] res, input logic [1:0] aluc);
        exp_t e;
        reset         = rst_v;
        bus.mem_ready = mr;
        e.idx = step_n; e.st = st; e.pcw = pcw; e.mw = mw; e.rw = rw;
        e.irw = irw; e.ill = ill; e.adr = adr; e.srca = srca;
        e.srcb = srcb; e.res = res; e.aluc = aluc;
        e.src_chk = 1'b0; e.imm = 2'b00; e.regs = 2'b00; e.ret = ret_exp;
        step_n++;
        sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic t_reset(input logic mr);
        step(1'b0, mr, 4'd0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00);
    endtask

    task automatic t_fetch(input logic mr);
        step(1'b1, mr, 4'd0, mr, 0, 0, mr, 0, 0, 1, 2'b10, 2'b10, 2'b00);
    endtask

    task automatic t_decode(input logic [31:0] ins, input logic ill,
                            input logic [1:0] imm, input logic [1:0] regs);
        bus.instruction = ins;
        step(1'b1, 1'b1, 4'd1, 0, 0, 0, 0, ill, 0, 1, 2'b10, 2'b10, 2'b00);
        sb[sb.size()-1].src_chk = 1'b1;
        sb[sb.size()-1].imm     = imm;
        sb[sb.size()-1].regs    = regs;
    endtask

    task automatic t_exec(input logic [3:0] st, input logic [1:0] srcb, input logic [1:0] aluc);
        step(1'b1, 1'b1, st, 0, 0, 0, 0, 0, 0, 0, srcb, 2'b00, aluc);
    endtask

    task automatic t_aluwb(input logic pcw);
        step(1'b1, 1'b1, 4'd8, pcw, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    endtask

    task automatic t_branch(input logic pcw);
        step(1'b1, 1'b1, 4'd9, pcw, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00);
    endtask

    task automatic t_memadr();
        step(1'b1, 1'b1, 4'd2, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
    endtask

    task automatic t_memread(input logic mr);
        step(1'b1, mr, 4'd3, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
    endtask

    task automatic t_memwrite(input logic mr, input logic mw);
        step(1'b1, mr, 4'd5, 0, mw, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
    endtask

    task automatic t_memwb();
        step(1'b1, 1'b1, 4'd4, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00);
    endtask

    // SUBS r0,r0,#0 style op: EXECUTER with SUB, flags presented at its end
    task automatic subs(input logic [3:0] flags);
        t_fetch(1'b1);
        t_decode(32'hE0500000, 1'b0, 2'b00, 2'b00);
        bus.alu_flags = flags;
        t_exec(4'd6, 2'b00, 2'b01);
        bus.alu_flags = 4'b0000;
        t_aluwb(1'b0);
        ret_exp++;
    endtask

    task automatic beq(input logic taken);
        t_fetch(1'b1);
        t_decode(32'h0A000002, 1'b0, 2'b10, 2'b01);
        t_branch(taken);
        ret_exp++;
    endtask

    initial begin
        reset           = 1'b0;
        bus.instruction = 32'h0;
        bus.alu_flags   = 4'b0000;
        bus.mem_ready   = 1'b1;
        @(posedge clock);
        #1;

        // Reset held: FETCH, no writes
        t_reset(1'b1);
        t_reset(1'b1);

        // ADD immediate: 0,1,7,8,0
        t_fetch(1'b1);
        t_decode(32'hE2821005, 1'b0, 2'b00, 2'b00);
        t_exec(4'd7, 2'b01, 2'b00);
        t_aluwb(1'b0);
        ret_exp++;

        // SUBS sets Z, BEQ taken; SUBS clears Z, BEQ not taken
        subs(4'b0100);
        beq(1'b1);
        subs(4'b0000);
        beq(1'b0);
        subs(4'b0100);

        // STRNE with Z=1: never writes; fetch stall first
        t_fetch(1'b0);
        t_fetch(1'b1);
        t_decode(32'h15810000, 1'b0, 2'b01, 2'b10);
        t_memadr();
        t_memwrite(1'b0, 1'b0);
        t_memwrite(1'b1, 1'b0);
        ret_exp++;

        // STR AL: write held across the whole stay
        t_fetch(1'b1);
        t_decode(32'hE5810000, 1'b0, 2'b01, 2'b10);
        t_memadr();
        t_memwrite(1'b0, 1'b1);
        t_memwrite(1'b1, 1'b1);
        ret_exp++;

        // LDR with three wait cycles in MEMREAD
        t_fetch(1'b1);
        t_decode(32'hE5910000, 1'b0, 2'b01, 2'b10);
        t_memadr();
        t_memread(1'b0);
        t_memread(1'b0);
        t_memread(1'b0);
        t_memread(1'b1);
        t_memwb();
        ret_exp++;

        // Undefined op: illegal in DECODE only, not retired
        t_fetch(1'b1);
        t_decode(32'hEC000000, 1'b1, 2'b11, 2'b00);

        // ADD with rd=15 writes PC in ALUWB
        t_fetch(1'b1);
        t_decode(32'hE080F000, 1'b0, 2'b00, 2'b00);
        t_exec(4'd6, 2'b00, 2'b00);
        t_aluwb(1'b1);
        ret_exp++;

        // ORR register form
        t_fetch(1'b1);
        t_decode(32'hE1800000, 1'b0, 2'b00, 2'b00);
        t_exec(4'd6, 2'b00, 2'b11);
        t_aluwb(1'b0);
        ret_exp++;

        // Reset asserted while in MEMREAD; NZCV must be cleared (BEQ not taken)
        t_fetch(1'b1);
        t_decode(32'hE5910000, 1'b0, 2'b01, 2'b10);
        t_memadr();
        ret_exp = 0;
        t_reset(1'b0);
        beq(1'b0);
        t_fetch(1'b1);

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge clock);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter RETIRE_W, default 32, width of the retired-instruction counter.
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  reset, asynchronous, active-low.
REQ-004 instruction  in  32  IR contents; cond=[31:28], op=[27:26], funct=[25:20], rd=[15:12].
REQ-005 alu_flags  in  4  NZCV from ALU, current cycle.
REQ-006 mem_ready  in  1  memory handshake; access completes in a cycle where it is 1.
REQ-007 pc_write  out  1  load PC from result.
REQ-008 address_source  out  1  memory address: 0=PC, 1=ALU-out register.
REQ-009 memory_write  out  1  data memory write enable.
REQ-010 ir_write  out  1  load instruction register.
REQ-011 register_write  out  1  register file write enable.
REQ-012 alu_source_a  out  1  0=register A, 1=PC.
REQ-013 alu_source_b  out  2  00=write data, 01=extended immediate, 10=constant 4.
REQ-014 result_source  out  2  00=ALU-out register, 01=read data, 10=ALU result.
REQ-015 immediate_source / register_source / alu_control  out  2 each  datapath selects.
REQ-016 illegal  out  1  one-cycle pulse on undefined op.
REQ-017 state  out  4  current state encoding (debug).
REQ-018 retired_count  out  RETIRE_W  present only with RETIRE_COUNT_EN.

Function
REQ-019 States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BRANCH 9; codes 10-15 SHALL go to FETCH.
REQ-020 FETCH: address_source 0, alu_source_a 1, alu_source_b 10, alu_control 00, result_source 10; ir_write=pc_write=mem_ready; -> DECODE on mem_ready, else hold.
REQ-021 DECODE: alu_source_a 1, alu_source_b 10, result_source 10; op00 & funct[5]=0 -> EXECUTER, op00 & funct[5]=1 -> EXECUTEI, op01 -> MEMADR, op10 -> BRANCH, op11 -> FETCH with illegal=1.
REQ-022 MEMADR: alu_source_a 0, alu_source_b 01, alu_control 00; funct[0]=1 -> MEMREAD, else MEMWRITE.
REQ-023 MEMREAD: address_source 1; hold until mem_ready, then -> MEMWB.
REQ-024 MEMWRITE: address_source 1, memory_write=cond_pass held for whole stay; -> FETCH on mem_ready.
REQ-025 MEMWB: result_source 01, register_write=cond_pass; ALUWB: result_source 00, register_write=cond_pass; both -> FETCH; pc_write=cond_pass when rd=15.
REQ-026 EXECUTER: alu_source_b 00; EXECUTEI: alu_source_b 01; both alu_source_a 0 -> ALUWB; alu_control from funct[4:1]: 0100->00, 0010->01, 0000->10, 1100->11, other->00.
REQ-027 BRANCH: alu_source_a 0, alu_source_b 01, register_source[0]=1, result_source 10, pc_write=cond_pass; -> FETCH.
REQ-028 immediate_source = op (00 data-proc, 01 memory, 10 branch); register_source = {op==01, op==10}.
REQ-029 Internal NZCV register; cond_pass from registered flags: EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL per Armv4; 1111 never passes.
REQ-030 NZCV loads alu_flags at end of EXECUTER/EXECUTEI when funct[0]=1 and cond_pass.
REQ-031 All outputs not listed for a state are 0; register_write, memory_write, pc_write never asserted when cond_pass=0, except pc_write in FETCH.
REQ-032 Latency at mem_ready=1: data-proc 4, LDR 5, STR 4, B 3 cycles; each mem_ready=0 cycle adds 1.

Reset
REQ-033 reset=0 SHALL immediately force state FETCH, NZCV 0000, counter 0, all outputs 0 (except combinational FETCH selects), including mid-instruction.
REQ-034 First FETCH occurs on the first rising clock edge after reset returns to 1.

Configuration
REQ-035 With RETIRE_COUNT_EN defined: retired_count increments, wrapping at all-ones to 0, on each transition to FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH (condition-failed included, illegal excluded); without it, the port and counter are absent.

Verification
REQ-036 reset driven 0 while in MEMREAD -> state 0, NZCV 0, register_write/memory_write 0 same cycle.
REQ-037 0xE2821005, mem_ready=1 -> states 0,1,7,8,0; alu_source_b 01 in EXECUTEI; register_write=1 only in ALUWB.
REQ-038 0xE0500000 with alu_flags 0100, then 0x0A000002 -> pc_write=1 in BRANCH; repeat with alu_flags 0000 -> pc_write=0.
REQ-039 0xE5910000, mem_ready=0 for 3 cycles in MEMREAD -> state 3 held 4 cycles, total 8 cycles, register_write=1 in MEMWB.
REQ-040 NZCV Z=1, 0x15810000 -> memory_write never 1, retired_count +1.
REQ-041 0xEC000000 -> illegal=1 in DECODE only, next state 0, retired_count unchanged.
